// File: rtl/bit_peel_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_peel_seq_pkg
// Description : Shared FSM encoding and width helpers for the bit peeler.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_peel_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_peel_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_peel_seq_if
// Description : Word-in / beat-out handshake bundle for the bit peeler.
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_peel_seq_if #(
    parameter int N = 32
) ();
    localparam int IDXW = bit_peel_seq_pkg::idx_width(N);

    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_data;
    logic            in_lsb_first;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_mask;
    logic [IDXW-1:0] out_idx;
    logic            out_last;
    logic            out_zero;
    logic            busy;

    modport master (
        output in_valid, in_data, in_lsb_first, out_ready,
        input  in_ready, out_valid, out_mask, out_idx, out_last, out_zero, busy
    );

    modport slave (
        input  in_valid, in_data, in_lsb_first, out_ready,
        output in_ready, out_valid, out_mask, out_idx, out_last, out_zero, busy
    );

endinterface
`default_nettype wire

// File: rtl/bit_peel_seq_isolate.sv
`default_nettype none
// ============================================================================
// Module      : bit_isolate
// Description : Combinational MSB/LSB isolator with index encode and residue.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_isolate
    import bit_peel_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic [N-1:0]              i_vec,
    input  wire logic                      i_lsb_first,
    output logic      [N-1:0]              o_mask,
    output logic      [idx_width(N)-1:0]   o_idx,
    output logic      [N-1:0]              o_rest
);
    localparam int             IDXW  = idx_width(N);
    localparam int             c_LOG = clog2(N);
    localparam logic [N-1:0]   c_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] w_smear [0:c_LOG];
    logic [N-1:0] w_msb_mask;
    logic [N-1:0] w_lsb_mask;

    assign w_smear[0] = i_vec;

    // Shifts stop at 2^(clog2(N)-1), which is always below N.
    generate
        for (genvar k = 0; k < c_LOG; k++) begin : g_smear
            assign w_smear[k+1] = w_smear[k] | (w_smear[k] >> (1 << k));
        end
    endgenerate

    assign w_msb_mask = w_smear[c_LOG] & ~(w_smear[c_LOG] >> 1);
    assign w_lsb_mask = i_vec & (~i_vec + c_ONE);
    assign o_mask     = i_lsb_first ? w_lsb_mask : w_msb_mask;
    assign o_rest     = i_vec & ~o_mask;

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (o_mask[i]) begin
                o_idx = o_idx | IDXW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bit_peel_seq.sv
`default_nettype none
// ============================================================================
// Module      : bit_peel_seq
// Description : Peels each set bit of a word out as one handshaked beat.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_peel_seq
    import bit_peel_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bit_peel_seq_if.slave    bus
);
    localparam int IDXW = idx_width(N);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [N-1:0]    r_residual;
    logic            r_mode;
    logic            r_zero;

    logic [N-1:0]    w_mask;
    logic [IDXW-1:0] w_idx;
    logic [N-1:0]    w_rest;
    logic            w_run;
    logic            w_last;
    logic            w_accept;
    logic            w_fire;

    bit_isolate #(.N(N)) u_isolate (
        .i_vec       (r_residual),
        .i_lsb_first (r_mode),
        .o_mask      (w_mask),
        .o_idx       (w_idx),
        .o_rest      (w_rest)
    );

    assign w_run    = (r_state == RUN);
    assign w_last   = r_zero | (w_rest == '0);
    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_fire   = w_run & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        bus.in_ready     = 1'b1;
        bus.out_valid    = 1'b0;
        bus.out_mask     = '0;
        bus.out_idx      = '0;
        bus.out_last     = 1'b0;
        bus.out_zero     = 1'b0;
        bus.busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // Ready on the last handshake lets the next word follow without a bubble.
                bus.in_ready  = w_last & bus.out_ready;
                bus.out_valid = 1'b1;
                bus.out_mask  = w_mask;
                bus.out_idx   = w_idx;
                bus.out_last  = w_last;
                bus.out_zero  = r_zero;
                bus.busy      = 1'b1;
                if (bus.out_ready && w_last && !bus.in_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_residual <= '0;
            r_mode     <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_residual <= bus.in_data;
            r_mode     <= bus.in_lsb_first;
            r_zero     <= (bus.in_data == '0);
        end else if (w_fire && !w_last) begin
            r_residual <= w_rest;
        end
    end

endmodule
`default_nettype wire

// File: doc/bit_peel_seq.md
Name: bit_peel_seq

Overview:
- Sequential successor to the combinational MSB isolator.
- Accepts an N-bit word over a valid/ready handshake.
- Emits every set bit as a one-hot mask plus binary index, one beat per handshake.
- Per-word mode selects MSB-first or LSB-first order.
- Used by the scheduler/arbiter paths to walk request vectors bit by bit under backpressure.

Parameters:
- N, 32, data width in bits; N >= 2, need not be a power of 2.
- IDXW, max(1, clog2(N)), width of the index output; derived, not to be overridden.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  N  word to peel
- in_lsb_first  input  1  0 = MSB-first, 1 = LSB-first; sampled with in_data
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts beat
- out_mask  output  N  one-hot isolated bit (all zero for a zero word)
- out_idx  output  IDXW  binary position of out_mask bit (0 for a zero word)
- out_last  output  1  this beat is the final beat of the word
- out_zero  output  1  accepted word was all zeros
- busy  output  1  high whenever state is RUN

Behaviour:
- Reset: state=IDLE, residual=0, mode=0, zero_flag=0.
  - Outputs in reset/IDLE: in_ready=1, out_valid=0, out_mask=0, out_idx=0, out_last=0, out_zero=0, busy=0.
  - rst overrides any in-flight word; the partial word is discarded silently and the next cycle is IDLE.
- State IDLE:
  - in_ready=1.
  - On in_valid: residual<=in_data, mode<=in_lsb_first, zero_flag<=(in_data==0), state<=RUN.
- State RUN:
  - out_valid=1, in_ready=0 except as in the back-to-back rule below.
  - Isolation is combinational from the registered residual:
    - MSB mode: smear residual right by 1, 2, 4, ... 2^(clog2(N)-1); mask = s & ~(s>>1).
    - LSB mode: mask = residual & (~residual + 1).
  - out_idx = encoded position of mask.
  - out_last = zero_flag OR ((residual & ~mask) == 0).
  - out_zero = zero_flag.
  - On out_valid & out_ready & !out_last: residual <= residual & ~mask; stay in RUN.
  - On out_valid & out_ready & out_last: go to IDLE.
  - Back-to-back exception: if in_valid is also high that cycle, load the new word and stay in RUN.
- in_ready formula: in_ready = (state==IDLE) | (state==RUN & out_last & out_ready). This gives zero-bubble back-to-back words.
- Latency and throughput:
  - Word accepted in cycle t gives its first out_valid in cycle t+1.
  - A word with popcount k takes max(k,1) beats.
  - Sustained throughput is one beat per cycle while out_ready=1.
- Backpressure: while out_valid & !out_ready, out_mask, out_idx, out_last and out_zero hold stable and residual does not change.
- Zero word: exactly one beat with out_mask=0, out_idx=0, out_last=1, out_zero=1.
- Single-bit word: one beat with out_last=1, out_zero=0.
- Full word (all ones): N beats; the mask walks N-1 down to 0 (MSB) or 0 up to N-1 (LSB).
- Non-power-of-2 N: smear shifts greater than N-1 are not generated; upper index codes are never produced.
- Mode is fixed per word; in_lsb_first is ignored outside an accept cycle.

Decomposition:
- Shared include: clog2 function and state encodings (IDLE=1'b0, RUN=1'b1).
- Sub-module bit_isolate:
  - Combinational.
  - Inputs: N-bit vector, lsb_first.
  - Outputs: one-hot mask, IDXW index, rest = vec & ~mask.
  - Reused by other arbiters.
- bit_peel_seq holds only the registers, the FSM and the handshake logic.

Test Plan:
- N=32, in_data=0xA0000005, lsb_first=0, out_ready=1 -> beats (0x80000000,31), (0x20000000,29), (0x00000004,2), (0x00000001,0,last) on cycles t+1..t+4.
- Same word, lsb_first=1 -> beats idx 0, 2, 29, 31; last on idx 31; in_ready=0 until the idx-31 handshake.
- in_data=0 -> single beat: out_mask=0, out_idx=0, out_last=1, out_zero=1; IDLE next cycle.
- 0x00000300 with out_ready low for 3 cycles on the first beat -> mask 0x200, idx 9 held stable for 3 cycles; then 0x100, idx 8, last.
- Back-to-back: 0x1 then 0x8000 presented continuously -> beats idx 0 (last) then idx 15 (last) on consecutive cycles, no bubble.
- rst asserted during the 2nd beat of 0xF -> next cycle out_valid=0, in_ready=1. Then word 0x2 -> single beat idx 1.
- N=5, in_data=5'b11111, MSB mode -> idx 4, 3, 2, 1, 0; out_idx width 3.
